// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stage.
//   - State encoding of the skid-buffered stage (EMPTY/ONE/TWO).
//   - Default EX/MEM control and data bundle widths, field offsets and
//     packing helpers so the stage can replace the fixed EX/MEM latch.
package pipe_pkg;

    // Stage state encoding; the value doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        StEmpty = ST_EMPTY,
        StOne   = ST_ONE,
        StTwo   = ST_TWO
    } pipe_state_e;

    // Default EX/MEM control bundle, MSB first: MemWrite .. RegWrite.
    localparam int unsigned EXMEM_CTRL_W  = 5;
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_BRANCH   = 2;
    localparam int unsigned CTRL_MEMREAD  = 3;
    localparam int unsigned CTRL_MEMWRITE = 4;

    typedef struct packed {
        logic mem_write;
        logic mem_read;
        logic branch;
        logic mem_to_reg;
        logic reg_write;
    } exmem_ctrl_t;

    // Default EX/MEM data bundle layout (LSB offsets).
    localparam int unsigned EXMEM_DATA_W = 106;
    localparam int unsigned RD_LSB       = 0;    // dest reg, 5 bits
    localparam int unsigned STORE_LSB    = 5;    // store data, 32 bits
    localparam int unsigned ALU_LSB      = 37;   // ALU result, 32 bits
    localparam int unsigned ZERO_LSB     = 69;   // ALU zero flag, 1 bit
    localparam int unsigned TARGET_LSB   = 70;   // branch target, 32 bits
    localparam int unsigned PAD_LSB      = 102;  // 4 pad bits, always zero

    function automatic logic [EXMEM_CTRL_W-1:0] pack_exmem_ctrl(input exmem_ctrl_t c);
        return c;
    endfunction

    function automatic logic [EXMEM_DATA_W-1:0] pack_exmem_data(
        input logic [31:0] target,
        input logic        zero,
        input logic [31:0] alu,
        input logic [31:0] store,
        input logic [4:0]  rd
    );
        return {4'b0000, target, zero, alu, store, rd};
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: saturating event counter.
//   clk_i   : rising-edge clock
//   rst_i   : asynchronous active-high reset, clears the count
//   inc_i   : count one event this cycle
//   count_o : current count, sticks at all-ones
module pipe_perf_cnt #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + {{(Width-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline-stage register with a 2-entry skid buffer.
// Carries a control and a data bundle under valid/ready; in_ready is a flop.
// Bubbles always present zero control so write enables never fire downstream.
//   Clk, Reset (async, active-high), Flush (sync squash of held entries)
//   in_valid/in_ready/in_ctrl/in_data    : upstream side
//   out_valid/out_ready/out_ctrl/out_data: downstream side
//   occupancy                            : entries held (0..2)
// Optional: define PIPE_STAGE_PERF_CNT_EN to add stall_cnt/bubble_cnt.
module pipe_stage_skid #(
    parameter int unsigned CTRL_W              = pipe_pkg::EXMEM_CTRL_W,
    parameter int unsigned DATA_W              = pipe_pkg::EXMEM_DATA_W,
    parameter bit          HOLD_DATA_ON_BUBBLE = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    import pipe_pkg::*;

    pipe_state_e       state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q;

    logic accept;
    logic drain;

    assign out_valid = (state_q != StEmpty);
    assign in_ready  = in_ready_q;
    assign occupancy = state_q;
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d     = StOne;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end
            StOne: begin
                if (accept && drain) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (accept) begin
                    // Downstream stalled: park the new entry behind main.
                    state_d     = StTwo;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end else if (drain) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    state_d     = StOne;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase

        // Squash wins over everything; register contents are left as they
        // were so a discarded accept never shows up on a held out_data.
        if (Flush) begin
            state_d     = StEmpty;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= (state_d != StTwo);
        end
    end

    always_comb begin
        out_ctrl = '0;
        out_data = '0;
        if (out_valid) begin
            out_ctrl = main_ctrl_q;
        end
        if (HOLD_DATA_ON_BUBBLE || out_valid) begin
            out_data = main_data_q;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic stall_evt;
    logic bubble_evt;

    assign stall_evt  = out_valid & ~out_ready;
    assign bubble_evt = ~out_valid;

    pipe_perf_cnt #(
        .Width(32)
    ) u_stall_cnt (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .inc_i  (stall_evt),
        .count_o(stall_cnt)
    );

    pipe_perf_cnt #(
        .Width(32)
    ) u_bubble_cnt (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .inc_i  (bubble_evt),
        .count_o(bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and randomised checks of pipe_stage_skid with
// a FIFO reference model; every comparison goes through check_eq.
module tb_pipe_stage_skid;

    logic         Clk;
    logic         Reset;
    logic         Flush;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_ctrl;
    logic [105:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   out_ctrl;
    logic [105:0] out_data;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  bubble_cnt;
`endif

    pipe_stage_skid u_dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Flush    (Flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: plain FIFO of {ctrl, data} plus registered ready.
    logic [110:0] mq[$];
    logic         rdy_m   = 1'b1;
    int unsigned  bub_m   = 0;
    int unsigned  stall_m = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rdy_m   = 1'b1;
        bub_m   = 0;
        stall_m = 0;
    endtask

    task automatic check_model();
        logic [110:0] f;
        check_eq("occupancy", 128'(occupancy), 128'(mq.size()));
        check_eq("in_ready", 128'(in_ready), 128'(rdy_m));
        check_eq("out_valid", 128'(out_valid), 128'(mq.size() != 0));
        if (mq.size() != 0) begin
            f = mq[0];
            check_eq("out_ctrl", 128'(out_ctrl), 128'(f[110:106]));
            check_eq("out_data", 128'(out_data), 128'(f[105:0]));
        end else begin
            check_eq("bubble_ctrl", 128'(out_ctrl), 128'(0));
        end
    endtask

    // Drive one cycle, advance past the edge, update the model and compare.
    task automatic step(input logic iv, input logic [4:0] ic, input logic [105:0] id,
                        input logic ordy, input logic fl);
        logic acc;
        logic drn;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        Flush     = fl;
        acc = iv & rdy_m;
        drn = (mq.size() != 0) & ordy;
        if (mq.size() == 0) bub_m++;
        else if (!ordy) stall_m++;
        @(posedge Clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back({ic, id});
        end
        rdy_m = (mq.size() != 2);
        check_model();
    endtask

    localparam logic [4:0] C = 5'b10101;

    initial begin
        logic [31:0]  seq;
        logic [105:0] d;
        Reset     = 1'b1;
        Flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        Reset = 1'b0;

        // Reset state.
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        check_eq("rst_out_data", 128'(out_data), 128'(0));
        check_eq("rst_occupancy", 128'(occupancy), 128'(0));
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));

        // Streaming at full throughput, one cycle latency.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, C, 106'(i), 1'b1, 1'b0);
            check_eq("stream_valid", 128'(out_valid), 128'(1));
            check_eq("stream_ctrl", 128'(out_ctrl), 128'(5'b10101));
            check_eq("stream_data", 128'(out_data), 128'(i));
            check_eq("stream_occ", 128'(occupancy), 128'(1));
        end
        step(1'b0, 5'd0, 106'd0, 1'b1, 1'b0);
        check_eq("stream_end_valid", 128'(out_valid), 128'(0));

        // Backpressure: fill to TWO, third entry held upstream.
        step(1'b1, C, 106'h11, 1'b0, 1'b0);
        check_eq("bp_occ1", 128'(occupancy), 128'(1));
        check_eq("bp_rdy1", 128'(in_ready), 128'(1));
        step(1'b1, C, 106'h22, 1'b0, 1'b0);
        check_eq("bp_occ2", 128'(occupancy), 128'(2));
        check_eq("bp_rdy2", 128'(in_ready), 128'(0));
        check_eq("bp_head", 128'(out_data), 128'(106'h11));
        step(1'b1, C, 106'h33, 1'b0, 1'b0);
        check_eq("bp_hold_occ", 128'(occupancy), 128'(2));
        step(1'b1, C, 106'h33, 1'b1, 1'b0);
        check_eq("bp_drain1", 128'(out_data), 128'(106'h22));
        check_eq("bp_drain1_occ", 128'(occupancy), 128'(1));
        check_eq("bp_drain1_rdy", 128'(in_ready), 128'(1));
        step(1'b1, C, 106'h33, 1'b1, 1'b0);
        check_eq("bp_drain2", 128'(out_data), 128'(106'h33));
        step(1'b0, 5'd0, 106'd0, 1'b1, 1'b0);
        check_eq("bp_empty", 128'(out_valid), 128'(0));

        // Flush while in TWO with an entry offered.
        step(1'b1, C, 106'h44, 1'b0, 1'b0);
        step(1'b1, C, 106'h55, 1'b0, 1'b0);
        check_eq("fl_pre_occ", 128'(occupancy), 128'(2));
        step(1'b1, C, 106'h66, 1'b0, 1'b1);
        check_eq("fl_valid", 128'(out_valid), 128'(0));
        check_eq("fl_ctrl", 128'(out_ctrl), 128'(0));
        check_eq("fl_occ", 128'(occupancy), 128'(0));
        check_eq("fl_rdy", 128'(in_ready), 128'(1));
        check_eq("fl_held_data", 128'(out_data), 128'(106'h44));
        step(1'b0, 5'd0, 106'd0, 1'b1, 1'b0);
        check_eq("fl_after_valid", 128'(out_valid), 128'(0));

        // Asynchronous reset mid-cycle while in ONE.
        step(1'b1, C, 106'h77, 1'b0, 1'b0);
        #3;
        Reset = 1'b1;
        #1;
        check_eq("ar_valid", 128'(out_valid), 128'(0));
        check_eq("ar_ctrl", 128'(out_ctrl), 128'(0));
        check_eq("ar_data", 128'(out_data), 128'(0));
        check_eq("ar_occ", 128'(occupancy), 128'(0));
        check_eq("ar_rdy", 128'(in_ready), 128'(1));
        #1;
        Reset = 1'b0;
        model_reset();
        step(1'b1, C, 106'h88, 1'b0, 1'b0);
        check_eq("ar_first_accept", 128'(out_data), 128'(106'h88));
        check_eq("ar_first_occ", 128'(occupancy), 128'(1));
        step(1'b0, 5'd0, 106'd0, 1'b1, 1'b0);

        // Random traffic against the reference FIFO, with rare flushes.
        seq = 32'd1000;
        for (int n = 0; n < 10000; n++) begin
            d = {10'd0, $urandom(), $urandom(), seq};
            seq++;
            step(1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), d,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
        end
        for (int n = 0; n < 4; n++) step(1'b0, 5'd0, 106'd0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_CNT_EN
        // Counters: 1 bubble on the accept edge, 10 stalls, 5 empty idles.
        #2;
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        model_reset();
        step(1'b1, C, 106'h99, 1'b0, 1'b0);
        for (int n = 0; n < 10; n++) step(1'b0, 5'd0, 106'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 106'd0, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) step(1'b0, 5'd0, 106'd0, 1'b0, 1'b0);
        check_eq("stall_cnt", 128'(stall_cnt), 128'(10));
        check_eq("bubble_cnt", 128'(bubble_cnt), 128'(6));
        check_eq("stall_cnt_model", 128'(stall_cnt), 128'(stall_m));
        check_eq("bubble_cnt_model", 128'(bubble_cnt), 128'(bub_m));
        step(1'b0, 5'd0, 106'd0, 1'b0, 1'b1);
        check_eq("bubble_cnt_flush", 128'(bubble_cnt), 128'(7));
        check_eq("stall_cnt_flush", 128'(stall_cnt), 128'(10));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
